// File: rtl/ysyx_22050133_rw_arbiter_pkg.sv
// Shared constants for the cache-side rw bus: AXI size/burst codes and
// the arbiter state encoding.
package ysyx_22050133_defines;

  localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
  localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
  localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
  localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

  localparam logic [1:0] AXI_BURST_TYPE_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_TYPE_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_TYPE_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_22050133_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the master that was not granted most recently.
module ysyx_22050133_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050133_rw_arbiter.sv
// Two-master (icache = m0, dcache/LSU = m1) to one-slave rw-bus arbiter.
// The grant is held from address handshake through the last data beat.
module ysyx_22050133_rw_arbiter
  import ysyx_22050133_defines::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (icache)
  input  logic                  m0_addr_valid_i,
  output logic                  m0_addr_ready_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [7:0]            m0_len_i,
  input  logic [2:0]            m0_size_i,
  input  logic [1:0]            m0_burst_i,
  input  logic                  m0_w_valid_i,
  output logic                  m0_w_ready_o,
  input  logic [DATA_WIDTH-1:0] m0_w_data_i,
  output logic                  m0_r_valid_o,
  input  logic                  m0_r_ready_i,
  output logic [DATA_WIDTH-1:0] m0_r_data_o,
  // master 1 (dcache / uncached LSU)
  input  logic                  m1_addr_valid_i,
  output logic                  m1_addr_ready_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [7:0]            m1_len_i,
  input  logic [2:0]            m1_size_i,
  input  logic [1:0]            m1_burst_i,
  input  logic                  m1_w_valid_i,
  output logic                  m1_w_ready_o,
  input  logic [DATA_WIDTH-1:0] m1_w_data_i,
  output logic                  m1_r_valid_o,
  input  logic                  m1_r_ready_i,
  output logic [DATA_WIDTH-1:0] m1_r_data_o,
  // slave (AXI bridge)
  output logic                  s_addr_valid_o,
  input  logic                  s_addr_ready_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [7:0]            s_len_o,
  output logic [2:0]            s_size_o,
  output logic [1:0]            s_burst_o,
  output logic                  s_if_o,
  output logic                  s_w_valid_o,
  output logic [DATA_WIDTH-1:0] s_w_data_o,
  input  logic                  s_w_ready_i,
  input  logic                  s_r_valid_i,
  input  logic [DATA_WIDTH-1:0] s_r_data_i,
  output logic                  s_r_ready_o,
  // debug
  output logic [1:0]            dbg_state_o
);

  // Every channel: a transfer happens in a cycle where valid and ready are
  // both high; a source holds valid (and payload) steady until accepted.

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic [7:0] beats_q, beats_d;
  logic       pick_grant;
  logic       data_hs;

  ysyx_22050133_rr_pick2 u_pick (
    .req_i   ({m1_addr_valid_i, m0_addr_valid_i}),
    .last_i  (last_q),
    .grant_o (pick_grant)
  );

  logic                  g_addr_valid;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic                  g_we;
  logic [7:0]            g_len;
  logic [2:0]            g_size;
  logic [1:0]            g_burst;
  logic                  g_w_valid;
  logic [DATA_WIDTH-1:0] g_w_data;
  logic                  g_r_ready;

  assign g_addr_valid = grant_q ? m1_addr_valid_i : m0_addr_valid_i;
  assign g_addr       = grant_q ? m1_addr_i       : m0_addr_i;
  assign g_we         = grant_q ? m1_we_i         : m0_we_i;
  assign g_len        = grant_q ? m1_len_i        : m0_len_i;
  assign g_size       = grant_q ? m1_size_i       : m0_size_i;
  assign g_burst      = grant_q ? m1_burst_i      : m0_burst_i;
  assign g_w_valid    = grant_q ? m1_w_valid_i    : m0_w_valid_i;
  assign g_w_data     = grant_q ? m1_w_data_i     : m0_w_data_i;
  assign g_r_ready    = grant_q ? m1_r_ready_i    : m0_r_ready_i;

  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      beats_q <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    beats_d = beats_q;
    data_hs = 1'b0;

    m0_addr_ready_o = 1'b0;
    m0_w_ready_o    = 1'b0;
    m0_r_valid_o    = 1'b0;
    m0_r_data_o     = '0;
    m1_addr_ready_o = 1'b0;
    m1_w_ready_o    = 1'b0;
    m1_r_valid_o    = 1'b0;
    m1_r_data_o     = '0;
    s_addr_valid_o  = 1'b0;
    s_addr_o        = '0;
    s_we_o          = 1'b0;
    s_len_o         = 8'd0;
    s_size_o        = 3'd0;
    s_burst_o       = 2'd0;
    s_if_o          = 1'b0;
    s_w_valid_o     = 1'b0;
    s_w_data_o      = '0;
    s_r_ready_o     = 1'b0;

    // Outputs are gated by rst so a mid-burst reset silences the bus at once.
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_addr_valid_i || m1_addr_valid_i) begin
            grant_d = pick_grant;
            state_d = ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          s_addr_valid_o = g_addr_valid;
          s_addr_o       = g_addr;
          s_we_o         = g_we;
          s_len_o        = g_len;
          s_size_o       = g_size;
          s_burst_o      = g_burst;
          s_if_o         = ~grant_q;
          if (grant_q) m1_addr_ready_o = s_addr_ready_i;
          else         m0_addr_ready_o = s_addr_ready_i;
          if (g_addr_valid && s_addr_ready_i) begin
            beats_d = g_len;
            we_d    = g_we;
            state_d = ARB_DATA;
          end
        end
        ARB_DATA: begin
          s_if_o = ~grant_q;
          if (we_q) begin
            s_w_valid_o = g_w_valid;
            s_w_data_o  = g_w_data;
            if (grant_q) m1_w_ready_o = s_w_ready_i;
            else         m0_w_ready_o = s_w_ready_i;
            data_hs = g_w_valid && s_w_ready_i;
          end else begin
            s_r_ready_o = g_r_ready;
            if (grant_q) begin
              m1_r_valid_o = s_r_valid_i;
              m1_r_data_o  = s_r_data_i;
            end else begin
              m0_r_valid_o = s_r_valid_i;
              m0_r_data_o  = s_r_data_i;
            end
            data_hs = s_r_valid_i && g_r_ready;
          end
          // beats holds the number of beats still to come after this one.
          if (data_hs) begin
            if (beats_q == 8'd0) begin
              last_d  = grant_q;
              state_d = ARB_IDLE;
            end else begin
              beats_d = beats_q - 8'd1;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22050133_rw_arbiter.md
Name: ysyx_22050133_rw_arbiter

Overview:
- Two-master to one-slave arbiter for the cache-side rw bus.
- Master 0 is the icache; master 1 is the dcache or uncached LSU path. The slave is the single AXI bridge.
- A grant is locked from address handshake through the final data beat, so bursts are never interleaved. Ties are resolved round-robin.

Parameters:
DATA_WIDTH, 64, rw data bus width
ADDR_WIDTH, 32, rw address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mN_addr_valid_i (N=0,1)  in  1  master address request
mN_addr_ready_o  out  1  address accepted
mN_addr_i  in  ADDR_WIDTH  request address
mN_we_i  in  1  1 = write burst, 0 = read burst
mN_len_i  in  8  beats minus 1
mN_size_i  in  3  AXI size code
mN_burst_i  in  2  AXI burst type
mN_w_valid_i  in  1  write beat valid
mN_w_ready_o  out  1  write beat accepted
mN_w_data_i  in  DATA_WIDTH  write beat data
mN_r_valid_o  out  1  read beat valid
mN_r_ready_i  in  1  master ready for read beat
mN_r_data_o  out  DATA_WIDTH  read beat data
s_addr_valid_o, s_addr_o, s_we_o, s_len_o, s_size_o, s_burst_o, s_if_o  out  1/ADDR_WIDTH/1/8/3/2/1  muxed request; s_if_o = 1 when master 0 is granted
s_addr_ready_i  in  1  slave accepts address
s_w_valid_o  out  1  muxed write beat valid
s_w_data_o  out  DATA_WIDTH  muxed write beat data
s_w_ready_i  in  1  slave accepts write beat
s_r_valid_i  in  1  slave read beat valid
s_r_data_i  in  DATA_WIDTH  slave read beat data
s_r_ready_o  out  1  muxed read ready

Behaviour:
- Registers:
  - state ∈ {IDLE, ADDR, DATA}
  - grant (1 bit)
  - last (1 bit; the master granted most recently)
  - we_q
  - beats (8 bits)
- Reset:
  - state=IDLE, grant=0, last=1 (so master 0 wins the first tie), beats=0.
  - All outputs are 0 during reset and in IDLE.
- IDLE:
  - Requests are sampled each cycle.
  - Only m0 valid → grant=0. Only m1 valid → grant=1.
  - Both valid → grant=~last.
  - Then go to ADDR. Arbitration latency is 1 cycle.
- ADDR:
  - All s_addr*/we/len/size/burst outputs are driven from the granted master.
  - s_addr_valid_o = mG_addr_valid_i; mG_addr_ready_o = s_addr_ready_i.
  - The other master's addr_ready = 0.
  - On handshake: beats<=len_i, we_q<=we_i, go to DATA.
  - If the granted master drops valid before the handshake, stay in ADDR. AXI forbids retraction, so no timeout is provided.
- DATA, write (we_q=1):
  - s_w_valid_o = mG_w_valid_i, s_w_data_o = mG_w_data_i, mG_w_ready_o = s_w_ready_i.
  - s_r_ready_o = 0.
- DATA, read (we_q=0):
  - mG_r_valid_o = s_r_valid_i, mG_r_data_o = s_r_data_i, s_r_ready_o = mG_r_ready_i.
  - Write-path outputs are 0.
- Beat counting and release:
  - Each data handshake with beats≠0 decrements beats.
  - The handshake with beats==0 is the last beat: set last<=grant and go to IDLE.
  - len=0 gives exactly one beat.
- Back-to-back transactions:
  - There is always ≥1 IDLE cycle between grants.
  - A dcache writeback followed by refill is two separate grants. The other master may slip in between; this is permitted because the cache holds its line locked.
- Non-granted master: all ready/valid outputs are 0; its r_data_o is 0.
- Unexpected slave beats: a slave r_valid in IDLE or ADDR is not forwarded, and s_r_ready_o = 0.
- Reset mid-burst: immediate return to IDLE and all outputs drop. Slave and masters are reset on the same rst.
- All muxing is combinational from the state and grant registers. There is no data-path register, so beat latency is 0.

Decomposition:
- Shared package (ysyx_22050133_defines): AXI_SIZE_BYTES_*, AXI_BURST_TYPE_* constants, state encodings ARB_IDLE/ARB_ADDR/ARB_DATA.
- One natural sub-module: ysyx_22050133_rr_pick2 (combinational two-way round-robin picker; inputs req[1:0] and last, output grant).

Test Plan:
- Icache read, m0 addr 0x80000000, len=7, slave returns data 0..7 with r_valid every cycle → m0 sees 8 beats in order; s_if_o=1; return to IDLE after beat 8; grant released.
- m0 and m1 request in the same cycle after reset → m0 granted first. m1 is granted in the first IDLE cycle after m0's last beat. With both still requesting, the next tie goes to m0.
- m1 write, len=7, with s_w_ready toggling 1/0 → exactly 8 w handshakes forwarded; s_we_o=1; m0 addr_ready stays 0 throughout.
- m1 single-beat read, len=0, with m1_r_ready low for 3 cycles while s_r_valid is held → s_r_ready_o is low for those cycles; the release happens on the single handshake.
- Slave asserts s_r_valid during IDLE → no master sees r_valid; s_r_ready_o=0.
- rst asserted on beat 3 of an 8-beat read → next cycle all outputs are 0 and state=IDLE. A new m1 request is granted within 2 cycles of rst deassertion.
